logic_unit_pipe: RTL and testbench

//  Parametrised, two-stage pipelined bitwise logic unit for the integer ALU datapath.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 99 +++++++++
 tb/tb_logic_unit_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Opcode encodings used by logic_unit_core and logic_unit_pipe.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NAND = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit logic function f(op, a, b).
// Operand b is ignored for NOT A and PASS A.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_NAND: y = ~(a & b);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with completed-result counter.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero/parity/all-ones flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [OP_W-1:0]    in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic               out_zero,
    output logic               out_parity,
    output logic               out_ones,
`endif
    output logic [COUNT_W-1:0] res_count
);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    logic             s1_valid;
    s1_t              s1_q;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] y_next;

    // A stage may load when it is empty or its contents move on this edge
    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{op: in_op, a: in_a, b: in_b};
            end
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (s1_q.op),
        .a  (s1_q.a),
        .b  (s1_q.b),
        .y  (y_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y <= y_next;
            end
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            out_ones   <= 1'b0;
        end else if (s2_load && s1_valid) begin
            out_zero   <= (y_next == '0);
            out_parity <= ^y_next;
            out_ones   <= (y_next == '1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= '0;
        end else if (out_valid && out_ready) begin
            res_count <= res_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: random traffic vs a truth-table model.
// Define LOGIC_UNIT_FLAGS_EN to also exercise the flag outputs.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       v8, r8, ov8, ordy8;
    logic [7:0] a8, b8, y8;
    logic [2:0] op8;
    logic [3:0] cnt8;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic       z8, p8, o8;
`endif

    logic        v1, r1, ov1, ordy1;
    logic        a1, b1, y1;
    logic [2:0]  op1;
    logic [15:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         exp_cnt = 0;
    logic       last_ov, last_acc;
    logic [7:0] last_y;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_ready  (r8),
        .in_a      (a8),
        .in_b      (b8),
        .in_op     (op8),
        .out_valid (ov8),
        .out_ready (ordy8),
        .out_y     (y8),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero  (z8),
        .out_parity(p8),
        .out_ones  (o8),
`endif
        .res_count (cnt8)
    );

    logic_unit_pipe #(.WIDTH(1), .COUNT_W(16)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_a      (a1),
        .in_b      (b1),
        .in_op     (op1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .out_y     (y1),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero  (),
        .out_parity(),
        .out_ones  (),
`endif
        .res_count (cnt1)
    );

    // Each op is a 4-entry truth table indexed by {a,b}; bit i of y uses bits i of a,b
    function automatic logic [7:0] model(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [31:0] tbl;
        logic [3:0]  tt;
        logic [7:0]  y;
        tbl = 32'hC396_1E87;
        tt  = tbl[op*4 +: 4];
        for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
        return y;
    endfunction

    // One cycle on the WIDTH=8 unit: drive, then predict handshakes and check outputs
    task automatic cyc8(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy);
        logic exp_ready;
        @(negedge clk);
        v8    = v;
        op8   = v ? op : 3'bx;
        a8    = v ? a : 8'bx;
        b8    = v ? b : 8'bx;
        ordy8 = ordy;
        #1;
        exp_ready = ordy || (exp_q.size() < 2);
        n_chk++;
        if (r8 !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready: got %b want %b", r8, exp_ready);
        end
        n_chk++;
        if (cnt8 !== 4'(exp_cnt)) begin
            n_fail++;
            $display("FAIL res_count: got %0d want %0d", cnt8, 4'(exp_cnt));
        end
        if (ov8) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_out: got y=%h with nothing pending", y8);
            end else if (y8 !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_y: got %h want %h", y8, exp_q[0]);
            end
`ifdef LOGIC_UNIT_FLAGS_EN
            if (exp_q.size() != 0) begin
                n_chk++;
                if ({z8, p8, o8} !== {exp_q[0] == 8'h00, ^exp_q[0], exp_q[0] == 8'hFF}) begin
                    n_fail++;
                    $display("FAIL flags: got %b%b%b for y=%h", z8, p8, o8, exp_q[0]);
                end
            end
`endif
            if (ordy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_cnt++;
            end
        end
        last_ov  = ov8;
        last_y   = y8;
        last_acc = v && r8;
        if (v && r8) exp_q.push_back(model(op, a, b));
    endtask

    task automatic drain8();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v8 = 1'b0; ordy8 = 1'b1; v1 = 1'b0; ordy1 = 1'b1;
        op8 = '0; a8 = '0; b8 = '0; op1 = '0; a1 = 1'b0; b1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({ov8, y8, cnt8, r8} !== {1'b0, 8'h00, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset8: got ov=%b y=%h cnt=%0d rdy=%b want 0 00 0 1", ov8, y8, cnt8, r8);
        end
        n_chk++;
        if ({ov1, y1, cnt1, r1} !== {1'b0, 1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset1: got ov=%b y=%b cnt=%0d rdy=%b want 0 0 0 1", ov1, y1, cnt1, r1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc8(1'b1, 3'd4, 8'hA5, 8'h0F, 1'b0);
        cyc8(1'b1, 3'd1, 8'h33, 8'hFF, 1'b0);
        cyc8(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ov8, cnt8, r8} !== {1'b0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset: got ov=%b cnt=%0d rdy=%b want 0 0 1", ov8, cnt8, r8);
        end
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
    endtask

    task automatic test_counter_wrap();
        for (int k = 0; k < 17; k++) begin
            cyc8(1'b1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'b1);
            n_chk++;
            if (!last_acc || (k >= 2 && !last_ov)) begin
                n_fail++;
                $display("FAIL sustained: cycle %0d got acc=%b ov=%b want 1 1", k, last_acc, last_ov);
            end
        end
        drain8();
        cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        n_chk++;
        if (cnt8 !== 4'd1) begin
            n_fail++;
            $display("FAIL count_wrap: got %0d want 1", cnt8);
        end
    endtask

    task automatic test_op_sweep();
        logic [63:0] want;
        logic [7:0]  w;
        want = 64'hF0_0F_C3_3C_03_FC_C0_3F;
        for (int op = 0; op < 8; op++) begin
            w = want[op*8 +: 8];
            cyc8(1'b1, 3'(op), 8'hF0, 8'hCC, 1'b1);
            cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
            n_chk++;
            if (last_ov !== 1'b0) begin
                n_fail++;
                $display("FAIL early_valid op%0d: got 1 want 0", op);
            end
            cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
            n_chk++;
            if (last_ov !== 1'b1 || last_y !== w) begin
                n_fail++;
                $display("FAIL sweep op%0d: got ov=%b y=%h want 1 %h", op, last_ov, last_y, w);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] it[4];
        int idx = 0;
        for (int i = 0; i < 4; i++) it[i] = 19'($urandom);
        for (int c = 0; c < 5; c++) begin
            cyc8(1'b1, it[idx][18:16], it[idx][15:8], it[idx][7:0], 1'b0);
            if (last_acc) idx++;
        end
        n_chk++;
        if (idx != 2) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d want 2", idx);
        end
        for (int g = 0; g < 20 && idx < 4; g++) begin
            cyc8(1'b1, it[idx][18:16], it[idx][15:8], it[idx][7:0], 1'b1);
            if (last_acc) idx++;
        end
        drain8();
    endtask

`ifdef LOGIC_UNIT_FLAGS_EN
    task automatic test_flags();
        cyc8(1'b1, 3'd4, 8'h5A, 8'h5A, 1'b1);
        cyc8(1'b1, 3'd0, 8'h00, 8'h00, 1'b1);
        cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        n_chk++;
        if ({z8, p8, o8} !== 3'b100) begin
            n_fail++;
            $display("FAIL flags_xor: got %b%b%b want 100", z8, p8, o8);
        end
        cyc8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        n_chk++;
        if ({z8, p8, o8} !== 3'b001) begin
            n_fail++;
            $display("FAIL flags_nand: got %b%b%b want 001", z8, p8, o8);
        end
        drain8();
    endtask
`endif

    task automatic test_width1();
        logic [7:0] m;
        logic [3:0] nand_tt;
        logic [1:0] ab;
        nand_tt = 4'b0111;
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 4; k++) begin
                ab = 2'(k);
                @(negedge clk);
                v1 = 1'b1; op1 = 3'(op); a1 = ab[1]; b1 = ab[0]; ordy1 = 1'b1;
                @(negedge clk);
                v1 = 1'b0; op1 = 3'bx; a1 = 1'bx; b1 = 1'bx;
                @(negedge clk);
                #1;
                m = model(3'(op), {7'd0, ab[1]}, {7'd0, ab[0]});
                n_chk++;
                if (ov1 !== 1'b1 || y1 !== m[0]) begin
                    n_fail++;
                    $display("FAIL w1 op%0d ab=%b: got ov=%b y=%b want 1 %b", op, ab, ov1, y1, m[0]);
                end
                if (op == 0) begin
                    n_chk++;
                    if (y1 !== nand_tt[ab]) begin
                        n_fail++;
                        $display("FAIL w1_nand ab=%b: got %b want %b", ab, y1, nand_tt[ab]);
                    end
                end
            end
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (cnt1 !== 16'd32 || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_count: got cnt=%0d ov=%b want 32 0", cnt1, ov1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            cyc8(1'($urandom_range(3) != 0), 3'($urandom_range(7)), 8'($urandom),
                 8'($urandom), 1'($urandom_range(2) != 0));
        end
        drain8();
    endtask

    initial begin
        test_reset();
        test_counter_wrap();
        test_op_sweep();
        test_backpressure();
`ifdef LOGIC_UNIT_FLAGS_EN
        test_flags();
`endif
        test_width1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
